// File: rtl/aes_round_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// aes_round_engine - iterative AES-128 encryptor, one round per clock, fed by
// the key expander's flattened round-key bus.              Revision: 1.0
// ---------------------------------------------------------------------------
module aes_round_engine #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  keys_ready,
  input  logic [(Nr+1)*128-1:0] all_keys,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          plaintext,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          ciphertext,
  output logic                  busy
);

  localparam int         RK_W = 32 * Nk;
  localparam logic [3:0] NR_4 = 4'(Nr);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box as GF(2^8) inverse (x^254, which also maps 0 to 0) plus the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] p;
    inv = 8'h01;
    p   = x;
    for (int i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox(s[8*k +: 8]);
    return o;
  endfunction

  // Byte k lives at bits [127-8k -: 8]; state is column-major (k = row + 4*col)
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  // Round keys indexed directly by the 4-bit counter; out-of-range slots read 0
  logic [127:0] rk [16];
  for (genvar r = 0; r < 16; r++) begin : g_rk
    if (r <= Nr) begin : g_used
      assign rk[r] = all_keys[(Nr+1)*RK_W-1-r*RK_W -: RK_W];
    end else begin : g_unused
      assign rk[r] = '0;
    end
  end

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] ct_q, ct_d;
  logic         out_valid_q, out_valid_d;

  logic [127:0] sb, sr, mc, key_cur;

  assign sb      = sub_bytes(state_q);
  assign sr      = shift_rows(sb);
  assign mc      = mix_columns(sr);
  assign key_cur = rk[round_q];

  assign in_ready   = (fsm_q == IDLE) && keys_ready && !reset;
  assign busy       = (fsm_q != IDLE);
  assign out_valid  = out_valid_q;
  assign ciphertext = ct_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= IDLE;
      round_q     <= 4'd0;
      state_q     <= '0;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      round_q     <= round_d;
      state_q     <= state_d;
      ct_q        <= ct_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    round_d     = round_q;
    state_d     = state_q;
    ct_d        = ct_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = plaintext ^ rk[0];
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        // Losing the key bus invalidates the in-flight block
        if (!keys_ready || round_q == 4'd0 || round_q > NR_4) begin
          fsm_d   = IDLE;
          round_d = 4'd0;
        end else if (round_q == NR_4) begin
          ct_d        = sr ^ key_cur;
          out_valid_d = 1'b1;
          fsm_d       = DONE;
        end else begin
          state_d = mc ^ key_cur;
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          round_d     = 4'd0;
          fsm_d       = IDLE;
        end
      end
      default: begin
        fsm_d       = IDLE;
        round_d     = 4'd0;
        out_valid_d = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_engine.sv
`timescale 1ns/1ps
`default_nettype none
// tb_aes_round_engine - vector table, directed handshake corners and random
// blocks checked against a byte-matrix AES-128 reference model.
module tb_aes_round_engine;

  localparam int NR = 10;
  localparam int KW = (NR+1)*128;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic          clk = 1'b0;
  logic          reset, keys_ready, in_valid, out_ready;
  logic [KW-1:0] all_keys;
  logic [127:0]  plaintext, ciphertext;
  logic          in_ready, out_valid, busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sbox_t [256];

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;
  vec_t vecs [8];

  aes_round_engine #(.Nk(4), .Nr(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .keys_ready(keys_ready),
    .all_keys  (all_keys),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .plaintext (plaintext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ciphertext(ciphertext),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [KW-1:0] expand_key(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [KW-1:0] ak;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++)
      ak[KW-1-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ak;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [KW-1:0] ak;
    logic [7:0]    st [4][4];
    logic [7:0]    tmp [4][4];
    logic [127:0]  k, o;
    ak = expand_key(key);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        st[r][c] = pt[127-8*(r+4*c) -: 8] ^ ak[KW-1-8*(r+4*c) -: 8];
    for (int rnd = 1; rnd <= NR; rnd++) begin
      k = ak[KW-1-128*rnd -: 128];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tmp[r][c] = sbox_t[st[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd < NR)
            st[r][c] = gmul(8'h02, tmp[r][c]) ^ gmul(8'h03, tmp[(r+1)%4][c]) ^
                       tmp[(r+2)%4][c] ^ tmp[(r+3)%4][c];
          else
            st[r][c] = tmp[r][c];
          st[r][c] ^= k[127-8*(r+4*c) -: 8];
        end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = st[r][c];
    return o;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_keys(input logic [127:0] key);
    keys_ready = 1'b0;
    tick();
    all_keys   = expand_key(key);
    keys_ready = 1'b1;
    #1;
  endtask

  task automatic accept(input string name, input logic [127:0] pt);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    check({name, " in_ready"}, 128'(in_ready), 128'(1));
    plaintext = pt;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  // ---------------- test ----------------
  initial begin
    int   lat, cyc, na, no;
    int   acc_c [2];
    logic [127:0] outs [2];
    logic bad, held;
    logic [127:0] ct_snap;

    build_sbox();
    vecs[0] = '{key: C1_KEY, pt: C1_PT, ct: C1_CT};
    vecs[1] = '{key: B_KEY,  pt: B_PT,  ct: B_CT};
    for (int i = 2; i < 8; i++) begin
      vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].ct  = ref_encrypt(vecs[i].key, vecs[i].pt);
    end

    // Reset state, with a block offered and keys valid
    reset      = 1'b1;
    keys_ready = 1'b1;
    all_keys   = expand_key(C1_KEY);
    in_valid   = 1'b1;
    plaintext  = C1_PT;
    out_ready  = 1'b0;
    #1;
    check("reset in_ready",   128'(in_ready),  128'(0));
    check("reset out_valid",  128'(out_valid), 128'(0));
    check("reset busy",       128'(busy),      128'(0));
    check("reset ciphertext", ciphertext,      128'(0));

    // Key gating: 20 cycles offered without keys
    keys_ready = 1'b0;
    tick();
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (in_ready || busy) bad = 1'b1;
    end
    check("gating no capture", 128'(bad), 128'(0));
    keys_ready = 1'b1;
    out_ready  = 1'b1;
    #1;
    check("gating first in_ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    check("gating accepted", 128'(busy), 128'(1));
    wait_out(lat);
    check("C1 latency", 128'(lat), 128'(10));
    check("C1 ciphertext", ciphertext, C1_CT);
    tick();
    check("C1 single-cycle valid", 128'(out_valid), 128'(0));

    // Back-to-back with in_valid and out_ready held high
    in_valid = 1'b1;
    plaintext = C1_PT;
    cyc = 0; na = 0; no = 0;
    while (no < 2 && cyc < 60) begin
      if (in_valid && in_ready && na < 2) begin
        acc_c[na] = cyc;
        na++;
      end
      tick();
      cyc++;
      if (na == 2) in_valid = 1'b0;
      if (out_valid && no < 2) begin
        outs[no] = ciphertext;
        no++;
      end
    end
    in_valid = 1'b0;
    check("b2b accept count", 128'(na), 128'(2));
    check("b2b output count", 128'(no), 128'(2));
    check("b2b accept spacing", 128'(acc_c[1] - acc_c[0]), 128'(12));
    check("b2b ct0", outs[0], C1_CT);
    check("b2b ct1", outs[1], C1_CT);

    // Appendix B with consumer stall
    tick();
    load_keys(B_KEY);
    out_ready = 1'b0;
    accept("B", B_PT);
    wait_out(lat);
    check("B latency", 128'(lat), 128'(10));
    check("B ciphertext", ciphertext, B_CT);
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!out_valid || ciphertext !== B_CT) held = 1'b0;
    end
    check("B held during stall", 128'(held), 128'(1));
    out_ready = 1'b1;
    tick();
    check("B valid drops", 128'(out_valid), 128'(0));
    check("B back to idle", 128'(busy), 128'(0));

    // Abort: keys_ready drops at round 5
    accept("abort", C1_PT);
    for (int i = 0; i < 4; i++) tick();
    keys_ready = 1'b0;
    tick();
    check("abort busy", 128'(busy), 128'(0));
    check("abort ct unchanged", ciphertext, B_CT);
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid || busy) bad = 1'b1;
    end
    check("abort no out_valid", 128'(bad), 128'(0));

    // Reset at round 3
    load_keys(C1_KEY);
    accept("rst", C1_PT);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("midreset outputs", {ciphertext[124:0], out_valid, busy, in_ready}, 128'(0));
    tick();
    reset = 1'b0;
    accept("post-reset", C1_PT);
    wait_out(lat);
    check("post-reset latency", 128'(lat), 128'(10));
    check("post-reset ct", ciphertext, C1_CT);
    tick();

    // out_ready pulses in IDLE and ROUND are ignored
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle out_ready ignored", 128'({busy, out_valid}), 128'(0));
    accept("ign", C1_PT);
    lat = 0;
    do begin
      out_ready = (lat == 3 || lat == 4);
      tick();
      lat++;
    end while (!out_valid && lat < 40);
    out_ready = 1'b0;
    check("ignored out_ready latency", 128'(lat), 128'(10));
    check("ignored out_ready ct", ciphertext, C1_CT);
    tick();
    check("ignored out_ready held", 128'(out_valid), 128'(1));
    out_ready = 1'b1;
    tick();

    // Vector table: FIPS vectors plus random blocks against the model
    for (int i = 0; i < 8; i++) begin
      load_keys(vecs[i].key);
      accept($sformatf("vec%0d", i), vecs[i].pt);
      wait_out(lat);
      check($sformatf("vec%0d latency", i), 128'(lat), 128'(10));
      check($sformatf("vec%0d ct", i), ciphertext, vecs[i].ct);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
